nn_sequencer: RTL and testbench

- Frame-level controller for the 4-neuron perceptron layer.
- Accepts a byte-serial frame from the pads: optionally 24 parameter bytes, then 4 input bytes. Steers each byte into the parameter register file or the input register with write strobes.
- Waits for the combinational layer to settle, then strobes output capture.
- Optionally feeds neuron outputs back as inputs for up to N_LAYERS passes, reusing the same weights.
- Replaces the free-running state counter between the pad interface and the parameter/input registers.

---
 rtl/nn_pkg.sv | 26 ++
 rtl/nn_byte_counter.sv | 41 ++++
 rtl/nn_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_nn_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the perceptron-layer frame sequencer: FSM encoding,
// layer geometry and parameter-byte field offsets.
package nn_pkg;

    localparam int N_NEURONS   = 4;
    localparam int N_PARAMS    = 6;
    localparam int PARAM_BYTES = N_NEURONS * N_PARAMS;

    localparam int FLD_W0 = 0;
    localparam int FLD_W1 = 1;
    localparam int FLD_W2 = 2;
    localparam int FLD_W3 = 3;
    localparam int FLD_B  = 4;
    localparam int FLD_TH = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_P   = 3'd1,
        ST_LOAD_X   = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_FEEDBACK = 3'd5,
        ST_DONE     = 3'd6
    } nn_state_e;

endpackage

// File: rtl/nn_byte_counter.sv
// Loadable up-counter that wraps to zero after LIMIT-1.
// Priority: clear, then load, then increment.
module nn_byte_counter #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/nn_sequencer.sv
// Frame controller for the perceptron layer: steers pad bytes into parameter/input
// registers (1-cycle strobe latency), then settles, captures and optionally feeds back.
module nn_sequencer
    import nn_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_LAYERS      = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       load_params_i,
    input  logic       abort_i,
    input  logic [7:0] data_in_i,
    input  logic       data_valid_i,
    output logic       param_we_o,
    output logic [4:0] param_addr_o,
    output logic [7:0] param_data_o,
    output logic       in_we_o,
    output logic [1:0] in_idx_o,
    output logic [7:0] in_data_o,
    output logic       feedback_sel_o,
    output logic       capture_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [2:0] state_o
);

    localparam logic [4:0] P_LAST     = 5'(PARAM_BYTES - 1);
    localparam logic [1:0] X_LAST     = 2'(N_NEURONS - 1);
    localparam logic [3:0] S_END      = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_LAYER = 2'(N_LAYERS - 1);

    nn_state_e  state_q, state_d;
    logic [1:0] layer_q, layer_d;

    logic       param_we_q, param_we_d;
    logic [4:0] param_addr_q, param_addr_d;
    logic [7:0] param_data_q, param_data_d;
    logic       in_we_q, in_we_d;
    logic [1:0] in_idx_q, in_idx_d;
    logic [7:0] in_data_q, in_data_d;
    logic       feedback_sel_q, feedback_sel_d;
    logic       capture_q, capture_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [4:0] p_cnt;
    logic [1:0] x_cnt;
    logic [3:0] s_cnt;
    logic       cnt_clr, p_inc, x_inc, s_clr, s_inc, s_load;

    nn_byte_counter #(.WIDTH(5), .LIMIT(PARAM_BYTES)) u_p_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(cnt_clr), .load_i(1'b0),
        .load_val_i(5'd0), .inc_i(p_inc), .cnt_o(p_cnt)
    );

    nn_byte_counter #(.WIDTH(2), .LIMIT(N_NEURONS)) u_x_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(cnt_clr), .load_i(1'b0),
        .load_val_i(2'd0), .inc_i(x_inc), .cnt_o(x_cnt)
    );

    nn_byte_counter #(.WIDTH(4), .LIMIT(16)) u_s_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(cnt_clr | s_clr), .load_i(s_load),
        .load_val_i(4'd1), .inc_i(s_inc), .cnt_o(s_cnt)
    );

    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        param_we_d     = 1'b0;
        param_addr_d   = 5'd0;
        param_data_d   = 8'd0;
        in_we_d        = 1'b0;
        in_idx_d       = 2'd0;
        in_data_d      = 8'd0;
        feedback_sel_d = 1'b0;
        capture_d      = 1'b0;
        done_d         = 1'b0;
        err_d          = err_q;
        cnt_clr        = 1'b0;
        p_inc          = 1'b0;
        x_inc          = 1'b0;
        s_clr          = 1'b0;
        s_inc          = 1'b0;
        s_load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start takes priority; a byte arriving with it is not consumed
                if (start_i) begin
                    err_d   = 1'b0;
                    state_d = load_params_i ? ST_LOAD_P : ST_LOAD_X;
                end else if (data_valid_i) begin
                    err_d = 1'b1;
                end
            end
            ST_LOAD_P: begin
                if (data_valid_i) begin
                    param_we_d   = 1'b1;
                    param_addr_d = p_cnt;
                    param_data_d = data_in_i;
                    p_inc        = 1'b1;
                    if (p_cnt == P_LAST) state_d = ST_LOAD_X;
                end
            end
            ST_LOAD_X: begin
                if (data_valid_i) begin
                    in_we_d   = 1'b1;
                    in_idx_d  = x_cnt;
                    in_data_d = data_in_i;
                    x_inc     = 1'b1;
                    if (x_cnt == X_LAST) begin
                        state_d = ST_SETTLE;
                        s_clr   = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                // the cycle carrying the last input strobe is settle count 0
                if (s_cnt == S_END) begin
                    state_d   = ST_CAPTURE;
                    capture_d = 1'b1;
                end else begin
                    s_inc = 1'b1;
                end
                if (data_valid_i) err_d = 1'b1;
            end
            ST_CAPTURE: begin
                if (layer_q < LAST_LAYER) begin
                    state_d        = ST_FEEDBACK;
                    feedback_sel_d = 1'b1;
                    in_we_d        = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
                if (data_valid_i) err_d = 1'b1;
            end
            ST_FEEDBACK: begin
                // the feedback strobe itself was this cycle, so settling starts at count 1
                layer_d = layer_q + 1'b1;
                state_d = ST_SETTLE;
                s_load  = 1'b1;
                if (data_valid_i) err_d = 1'b1;
            end
            ST_DONE: begin
                layer_d = 2'd0;
                state_d = ST_IDLE;
                if (data_valid_i) err_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                layer_d = 2'd0;
                cnt_clr = 1'b1;
            end
        endcase

        if (start_i && state_q != ST_IDLE) err_d = 1'b1;

        if (abort_i) begin
            state_d        = ST_IDLE;
            layer_d        = 2'd0;
            err_d          = err_q;
            cnt_clr        = 1'b1;
            p_inc          = 1'b0;
            x_inc          = 1'b0;
            s_inc          = 1'b0;
            s_load         = 1'b0;
            param_we_d     = 1'b0;
            in_we_d        = 1'b0;
            feedback_sel_d = 1'b0;
            capture_d      = 1'b0;
            done_d         = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            layer_q        <= 2'd0;
            param_we_q     <= 1'b0;
            param_addr_q   <= 5'd0;
            param_data_q   <= 8'd0;
            in_we_q        <= 1'b0;
            in_idx_q       <= 2'd0;
            in_data_q      <= 8'd0;
            feedback_sel_q <= 1'b0;
            capture_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            layer_q        <= layer_d;
            param_we_q     <= param_we_d;
            param_addr_q   <= param_addr_d;
            param_data_q   <= param_data_d;
            in_we_q        <= in_we_d;
            in_idx_q       <= in_idx_d;
            in_data_q      <= in_data_d;
            feedback_sel_q <= feedback_sel_d;
            capture_q      <= capture_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign param_we_o     = param_we_q;
    assign param_addr_o   = param_addr_q;
    assign param_data_o   = param_data_q;
    assign in_we_o        = in_we_q;
    assign in_idx_o       = in_idx_q;
    assign in_data_o      = in_data_q;
    assign feedback_sel_o = feedback_sel_q;
    assign capture_o      = capture_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_nn_sequencer.sv
// Drives identical frames into a single-layer and a three-layer sequencer and
// compares their strobe streams against timelines built from the frame rules.
module tb_nn_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       load_params = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;

    logic       pw1, iw1, fb1, cap1, busy1, done1, err1;
    logic [4:0] pa1;
    logic [7:0] pd1, id1;
    logic [1:0] ii1;
    logic [2:0] st1;
    logic       pw3, iw3, fb3, cap3, busy3, done3, err3;
    logic [4:0] pa3;
    logic [7:0] pd3, id3;
    logic [1:0] ii3;
    logic [2:0] st3;

    nn_sequencer #(.SETTLE_CYCLES(2), .N_LAYERS(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .load_params_i(load_params),
        .abort_i(abort), .data_in_i(data_in), .data_valid_i(data_valid),
        .param_we_o(pw1), .param_addr_o(pa1), .param_data_o(pd1),
        .in_we_o(iw1), .in_idx_o(ii1), .in_data_o(id1), .feedback_sel_o(fb1),
        .capture_o(cap1), .busy_o(busy1), .done_o(done1), .err_o(err1), .state_o(st1)
    );

    nn_sequencer #(.SETTLE_CYCLES(2), .N_LAYERS(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .load_params_i(load_params),
        .abort_i(abort), .data_in_i(data_in), .data_valid_i(data_valid),
        .param_we_o(pw3), .param_addr_o(pa3), .param_data_o(pd3),
        .in_we_o(iw3), .in_idx_o(ii3), .in_data_o(id3), .feedback_sel_o(fb3),
        .capture_o(cap3), .busy_o(busy3), .done_o(done3), .err_o(err3), .state_o(st3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit err_exp = 1'b0;
    logic [63:0] act1[$];
    logic [63:0] act3[$];

    localparam int K_PW = 1, K_IW = 2, K_FB = 3, K_CAP = 4, K_DONE = 5;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ev(input int k, input int a, input int b, input int t);
        return {8'(k), 8'(a), 8'(b), 8'h00, 32'(t)};
    endfunction

    always @(negedge clk) begin
        if (pw1)        act1.push_back(ev(K_PW, pa1, pd1, cyc));
        if (iw1 && !fb1) act1.push_back(ev(K_IW, ii1, id1, cyc));
        if (fb1)        act1.push_back(ev(K_FB, iw1, ii1, cyc));
        if (cap1)       act1.push_back(ev(K_CAP, 0, 0, cyc));
        if (done1)      act1.push_back(ev(K_DONE, 0, 0, cyc));
        if (pw3)        act3.push_back(ev(K_PW, pa3, pd3, cyc));
        if (iw3 && !fb3) act3.push_back(ev(K_IW, ii3, id3, cyc));
        if (fb3)        act3.push_back(ev(K_FB, iw3, ii3, cyc));
        if (cap3)       act3.push_back(ev(K_CAP, 0, 0, cyc));
        if (done3)      act3.push_back(ev(K_DONE, 0, 0, cyc));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input logic [63:0] a[$], input int base,
                         input logic [63:0] e[$]);
        chk({tag, "_count"}, 64'(a.size() - base), 64'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (base + i < a.size()) chk({tag, "_event"}, a[base + i], e[i]);
    endtask

    function automatic logic [32:0] outs(input int which);
        if (which == 1)
            return {pw1, pa1, pd1, iw1, ii1, id1, fb1, cap1, busy1, done1, err1, st1};
        return {pw3, pa3, pd3, iw3, ii3, id3, fb3, cap3, busy3, done3, err3, st3};
    endfunction

    // One frame. gap_fix<0 gives random 0..3 idle cycles before each byte; base<0 gives
    // random bytes. Optional faults: byte alongside start, start during LOAD_X,
    // byte during SETTLE, abort after abort_at bytes, async reset during SETTLE.
    task automatic run_frame(input string name, input bit lp, input int gap_fix, input int base,
                             input bit st_dv, input bit st_lx, input bit dv_st,
                             input int abort_at, input bit rst_st);
        logic [7:0]  by[$];
        int          tt[$];
        logic [63:0] e[$];
        int npar = lp ? 24 : 0;
        int nb   = (abort_at >= 0) ? abort_at : npar + 4;
        int b1   = act1.size();
        int b3   = act3.size();
        int g;
        int c;

        @(posedge clk); #1;
        start = 1'b1; load_params = lp;
        if (st_dv) begin data_valid = 1'b1; data_in = 8'($urandom); end
        @(posedge clk); #1;
        start = 1'b0; load_params = 1'b0; data_valid = 1'b0;
        chk({name, "_err_cleared_1"}, 64'(err1), 64'(0));
        chk({name, "_err_cleared_3"}, 64'(err3), 64'(0));
        err_exp = 1'b0;

        for (int i = 0; i < nb; i++) begin
            g = (gap_fix >= 0) ? gap_fix : int'($urandom_range(0, 3));
            if (st_lx && i == npar + 1 && g == 0) g = 1;
            for (int k = 0; k < g; k++) begin
                if (st_lx && i == npar + 1 && k == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            data_valid = 1'b1;
            data_in = (base >= 0) ? 8'(base + i) : 8'($urandom);
            by.push_back(data_in);
            tt.push_back(cyc);
            @(posedge clk); #1;
            data_valid = 1'b0;
        end
        if (st_lx) err_exp = 1'b1;

        if (abort_at >= 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk({name, "_abort_state_1"}, 64'(st1), 64'(0));
            chk({name, "_abort_state_3"}, 64'(st3), 64'(0));
            chk({name, "_abort_busy_1"}, 64'(busy1), 64'(0));
        end
        if (dv_st) begin
            data_valid = 1'b1;
            data_in = 8'($urandom);
            @(posedge clk); #1;
            data_valid = 1'b0;
            err_exp = 1'b1;
        end
        if (rst_st) begin
            @(posedge clk); #1;
            chk({name, "_pre_reset_state_1"}, 64'(st1), 64'(3));
            chk({name, "_pre_reset_state_3"}, 64'(st3), 64'(3));
            rst_n = 1'b0;
            #1;
            chk({name, "_reset_outs_1"}, 64'(outs(1)), 64'(0));
            chk({name, "_reset_outs_3"}, 64'(outs(3)), 64'(0));
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk); #1;
            chk({name, "_post_reset_state"}, 64'(st1), 64'(0));
            chk({name, "_post_reset_busy"}, 64'(busy3), 64'(0));
            err_exp = 1'b0;
        end

        repeat (20) @(posedge clk);
        #1;

        for (int layers = 1; layers <= 3; layers += 2) begin
            e.delete();
            for (int i = 0; i < nb; i++) begin
                if (i < npar) e.push_back(ev(K_PW, i, by[i], tt[i] + 1));
                else          e.push_back(ev(K_IW, i - npar, by[i], tt[i] + 1));
            end
            if (abort_at < 0 && !rst_st) begin
                c = tt[nb - 1] + 1 + 3;
                e.push_back(ev(K_CAP, 0, 0, c));
                for (int l = 1; l < layers; l++) begin
                    e.push_back(ev(K_FB, 1, 0, c + 1));
                    c = c + 4;
                    e.push_back(ev(K_CAP, 0, 0, c));
                end
                e.push_back(ev(K_DONE, 0, 0, c + 1));
            end
            if (layers == 1) cmp_q({name, "_L1"}, act1, b1, e);
            else             cmp_q({name, "_L3"}, act3, b3, e);
        end

        chk({name, "_err_1"}, 64'(err1), 64'(err_exp));
        chk({name, "_err_3"}, 64'(err3), 64'(err_exp));
        chk({name, "_idle_busy_1"}, 64'(busy1), 64'(0));
        chk({name, "_idle_busy_3"}, 64'(busy3), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_1", 64'(outs(1)), 64'(0));
        chk("reset_outs_3", 64'(outs(3)), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame("full",      1'b1,  0, 8'h01, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_frame("inputs",    1'b0,  3, 8'hA0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_frame("start_lx",  1'b0, -1,    -1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        run_frame("dv_settle", 1'b1, -1,    -1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        run_frame("start_dv",  1'b0,  0,    -1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        run_frame("abort",     1'b1,  0, 8'h30, 1'b0, 1'b0, 1'b0, 10, 1'b0);
        run_frame("restart",   1'b1,  0, 8'h40, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_frame("rst_mid",   1'b0,  1, 8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        for (int r = 0; r < 10; r++)
            run_frame($sformatf("rand%0d", r), 1'($urandom), -1, -1,
                      1'($urandom), 1'b0, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
